// File: rtl/instruction_fetch_unit_if.sv
// Instruction fetch bus: memory read port, decode hand-off and redirect.
//   master : the fetch unit (drives mem_addr, out_*, halted, fault)
//   slave  : the environment (memory, decoder, branch unit)
// Signals:
//   mem_addr / mem_instr / mem_next : byte address and combinational bytes at addr, addr+1
//   out_valid / out_ready           : decode hand-off handshake
//   out_instr / out_operand / out_pc / out_two_byte : issued instruction fields
//   redirect_valid / redirect_addr  : taken branch/jump target
//   halted / fault                  : fetch status flags
interface instruction_fetch_unit_if;
    logic [7:0] mem_addr;
    logic [7:0] mem_instr;
    logic [7:0] mem_next;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_instr;
    logic [7:0] out_operand;
    logic [7:0] out_pc;
    logic       out_two_byte;
    logic       redirect_valid;
    logic [7:0] redirect_addr;
    logic       halted;
    logic       fault;

    modport master (
        output mem_addr,
        input  mem_instr,
        input  mem_next,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_operand,
        output out_pc,
        output out_two_byte,
        input  redirect_valid,
        input  redirect_addr,
        output halted,
        output fault
    );

    modport slave (
        input  mem_addr,
        output mem_instr,
        output mem_next,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_operand,
        input  out_pc,
        input  out_two_byte,
        output redirect_valid,
        output redirect_addr,
        input  halted,
        input  fault
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit for the 4-bit CPU.
// Owns the program counter, reads one- or two-byte instructions from the
// combinational instruction memory and presents them to decode over a
// valid/ready hand-off. Handles branch redirects, HALT and the two-byte
// instruction at address 255 fault.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : instruction_fetch_unit_if.master (memory port, decode output,
//           redirect input, halted/fault status)
module instruction_fetch_unit #(
    parameter logic [7:0]  RESET_PC      = 8'h00,
    parameter logic [15:0] TWO_BYTE_MASK = 16'h7000,
    parameter logic [7:0]  HALT_INSTR    = 8'hF0
) (
    input  logic                             clk,
    input  logic                             reset,
    instruction_fetch_unit_if.master         bus
);

    typedef enum logic [1:0] {
        RUN,
        HALTED,
        FAULT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic       valid_q, valid_d;
    logic [7:0] instr_q, instr_d;
    logic [7:0] operand_q, operand_d;
    logic [7:0] out_pc_q, out_pc_d;
    logic       two_q, two_d;

    logic two;
    logic fire;
    logic consume;

    always_comb begin
        two     = TWO_BYTE_MASK[bus.mem_instr[7:4]];
        fire    = (state_q == RUN) && !bus.redirect_valid && (!valid_q || bus.out_ready);
        consume = valid_q && bus.out_ready;

        state_d   = state_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        instr_d   = instr_q;
        operand_d = operand_q;
        out_pc_d  = out_pc_q;
        two_d     = two_q;

        if (bus.redirect_valid && state_q != FAULT) begin
            // Flush wins over any refill; an acceptance this cycle still stands.
            pc_d    = bus.redirect_addr;
            valid_d = 1'b0;
            state_d = RUN;
        end else if (fire) begin
            if (two && pc_q == 8'hFF) begin
                // Operand would lie past the end of memory: issue nothing, park PC.
                state_d = FAULT;
                if (consume) begin
                    valid_d = 1'b0;
                end
            end else begin
                instr_d   = bus.mem_instr;
                operand_d = two ? bus.mem_next : '0;
                out_pc_d  = pc_q;
                two_d     = two;
                valid_d   = 1'b1;
                pc_d      = pc_q + (two ? 8'd2 : 8'd1);
                if (bus.mem_instr == HALT_INSTR) begin
                    state_d = HALTED;
                end
            end
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            valid_q   <= 1'b0;
            instr_q   <= '0;
            operand_q <= '0;
            out_pc_q  <= '0;
            two_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            operand_q <= operand_d;
            out_pc_q  <= out_pc_d;
            two_q     <= two_d;
        end
    end

    assign bus.mem_addr     = pc_q;
    assign bus.out_valid    = valid_q;
    assign bus.out_instr    = instr_q;
    assign bus.out_operand  = operand_q;
    assign bus.out_pc       = out_pc_q;
    assign bus.out_two_byte = two_q;
    assign bus.halted       = (state_q == HALTED);
    assign bus.fault        = (state_q == FAULT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    localparam logic [7:0]  RST_PC = 8'h00;
    localparam logic [15:0] MASK   = 16'h7000;
    localparam logic [7:0]  HALT   = 8'hF0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_fetch_unit_if bus();

    instruction_fetch_unit #(
        .RESET_PC      (RST_PC),
        .TWO_BYTE_MASK (MASK),
        .HALT_INSTR    (HALT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem [256];
    assign bus.mem_instr = mem[bus.mem_addr];
    assign bus.mem_next  = (bus.mem_addr == 8'hFF) ? 8'h00 : mem[bus.mem_addr + 8'd1];

    int checks = 0;
    int errors = 0;

    // Reference model: architectural view of the fetch unit.
    int m_pc;
    bit m_valid, m_two, m_halted, m_fault;
    int m_instr, m_op, m_opc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit rdy, input bit rv, input int ra);
        logic [7:0] b;
        bit is_two, accepted, running;
        if (rst) begin
            m_pc = RST_PC; m_valid = 0; m_instr = 0; m_op = 0; m_opc = 0;
            m_two = 0; m_halted = 0; m_fault = 0;
            return;
        end
        b        = mem[m_pc];
        is_two   = MASK[b[7:4]];
        accepted = m_valid && rdy;
        running  = !m_halted && !m_fault;
        if (rv && !m_fault) begin
            m_pc = ra; m_valid = 0; m_halted = 0;
        end else if (running && (!m_valid || rdy)) begin
            if (is_two && m_pc == 255) begin
                m_fault = 1;
                if (accepted) m_valid = 0;
            end else begin
                m_instr = b;
                m_op    = is_two ? int'(mem[(m_pc + 1) % 256]) : 0;
                m_opc   = m_pc;
                m_two   = is_two;
                m_valid = 1;
                m_pc    = (m_pc + (is_two ? 2 : 1)) % 256;
                if (b == HALT) m_halted = 1;
            end
        end else if (accepted) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all();
        check("mem_addr",     32'(bus.mem_addr),     32'(m_pc));
        check("out_valid",    32'(bus.out_valid),    32'(m_valid));
        check("out_instr",    32'(bus.out_instr),    32'(m_instr));
        check("out_operand",  32'(bus.out_operand),  32'(m_op));
        check("out_pc",       32'(bus.out_pc),       32'(m_opc));
        check("out_two_byte", 32'(bus.out_two_byte), 32'(m_two));
        check("halted",       32'(bus.halted),       32'(m_halted));
        check("fault",        32'(bus.fault),        32'(m_fault));
    endtask

    // Drives inputs just after an edge, advances the model, and compares after the next edge.
    task automatic cycle(input bit rst, input bit rdy, input bit rv, input int ra);
        reset              = rst;
        bus.out_ready      = rdy;
        bus.redirect_valid = rv;
        bus.redirect_addr  = ra[7:0];
        model_step(rst, rdy, rv, ra);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic load_program();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h21; mem[1] = 8'h35; mem[2] = 8'hC7;
        mem[3] = 8'h9A; mem[4] = 8'h10; mem[5] = HALT;
        mem[8'h40] = 8'h11;
    endtask

    initial begin
        reset              = 1'b1;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = 8'h00;
        load_program();

        // Straight-line issue with ready high
        cycle(1, 0, 0, 0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_addr",  32'(bus.mem_addr),  32'(RST_PC));
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        check("seq0_pc", 32'(bus.out_pc), 32'h00); check("seq0_instr", 32'(bus.out_instr), 32'h21);
        cycle(0, 1, 0, 0);
        check("seq1_pc", 32'(bus.out_pc), 32'h01); check("seq1_instr", 32'(bus.out_instr), 32'h35);
        cycle(0, 1, 0, 0);
        check("seq2_pc", 32'(bus.out_pc), 32'h02); check("seq2_op", 32'(bus.out_operand), 32'h9A);
        check("seq2_two", 32'(bus.out_two_byte), 32'd1);
        cycle(0, 1, 0, 0);
        check("seq3_pc", 32'(bus.out_pc), 32'h04); check("seq3_op", 32'(bus.out_operand), 32'h00);
        cycle(0, 1, 0, 0);
        check("halt_pc", 32'(bus.out_pc), 32'h05); check("halt_flag", 32'(bus.halted), 32'd1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
        check("halt_no_valid", 32'(bus.out_valid), 32'd0);
        cycle(0, 1, 1, 8'h00);
        check("halt_exit", 32'(bus.halted), 32'd0);
        cycle(0, 1, 0, 0);
        check("resume_pc", 32'(bus.out_pc), 32'h00); check("resume_valid", 32'(bus.out_valid), 32'd1);

        // Stall holds the issued instruction and the PC
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0);
            check("stall_pc", 32'(bus.out_pc), 32'h00);
            check("stall_instr", 32'(bus.out_instr), 32'h21);
            check("stall_addr", 32'(bus.mem_addr), 32'h01);
        end
        cycle(0, 1, 0, 0);
        check("unstall_pc", 32'(bus.out_pc), 32'h01);
        cycle(0, 1, 0, 0);

        // Redirect flushes the in-flight instruction
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 1, 8'h40);
        check("redir_flush", 32'(bus.out_valid), 32'd0);
        check("redir_addr", 32'(bus.mem_addr), 32'h40);
        cycle(0, 1, 0, 0);
        check("redir_pc", 32'(bus.out_pc), 32'h40);

        // Two-byte instruction at 0xFF faults; only reset recovers
        mem[8'hFF] = 8'hD1;
        cycle(0, 1, 1, 8'hFF);
        cycle(0, 1, 0, 0);
        check("fault_set", 32'(bus.fault), 32'd1);
        check("fault_pc", 32'(bus.mem_addr), 32'hFF);
        cycle(0, 1, 1, 8'h10);
        check("fault_ignore_redir", 32'(bus.mem_addr), 32'hFF);
        cycle(0, 1, 0, 0);
        check("fault_sticky", 32'(bus.fault), 32'd1);
        cycle(1, 1, 0, 0);
        check("fault_clear", 32'(bus.fault), 32'd0);

        // One-byte instruction at 0xFF wraps to 0
        mem[8'hFF] = 8'h21;
        cycle(0, 1, 1, 8'hFF);
        cycle(0, 1, 0, 0);
        check("wrap_ff", 32'(bus.out_pc), 32'hFF);
        cycle(0, 1, 0, 0);
        check("wrap_00", 32'(bus.out_pc), 32'h00);

        // Randomized traffic against the model
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] = 8'($urandom);
                if ($urandom_range(0, 40) == 0) mem[i] = HALT;
            end
            for (int i = 0; i < 1000; i++) begin
                bit rst, rdy, rv;
                int ra;
                rst = ($urandom_range(0, 199) == 0);
                rdy = ($urandom_range(0, 3) != 0);
                rv  = ($urandom_range(0, 11) == 0);
                ra  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8'hFC, 8'hFF))
                                                  : int'($urandom_range(0, 255));
                cycle(rst, rdy, rv, ra);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory read port: owns the program counter, drives the byte address, and samples the combinational instruction byte and lookahead byte.
- Assembles one- or two-byte instructions and hands them to decode over a valid/ready interface.
- Handles branch redirects, HALT, and the end-of-memory two-byte fault.
- Sits between instruction memory and the decoder in the 4-bit CPU.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- TWO_BYTE_MASK, 16'h7000, bit i set means opcode nibble i (instr[7:4]) is a two-byte instruction.
- HALT_INSTR, 8'hF0, exact byte value that halts fetch.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_addr  out  8  address to instruction memory; always equals the internal PC.
- mem_instr  in  8  byte at mem_addr, combinational response from memory.
- mem_next  in  8  byte at mem_addr+1; memory returns 0 when mem_addr is 255.
- out_valid  out  1  out_* fields hold a valid instruction.
- out_ready  in  1  decoder accepts the instruction this cycle.
- out_instr  out  8  opcode byte.
- out_operand  out  8  second byte for two-byte instructions, else 0.
- out_pc  out  8  address of out_instr.
- out_two_byte  out  1  instruction is two bytes.
- redirect_valid  in  1  branch/jump taken; load redirect_addr.
- redirect_addr  in  8  new PC.
- halted  out  1  FSM is in HALTED.
- fault  out  1  sticky flag: two-byte instruction found at address 255.

Behaviour:
- Reset (synchronous, dominates all other inputs): PC=RESET_PC, state=RUN; out_valid, out_instr, out_operand, out_pc, out_two_byte, halted and fault all 0.
- States: RUN, HALTED, FAULT.
  - halted=1 only in HALTED.
  - fault=1 only in FAULT; FAULT is left only by reset.
- Definitions:
  - two = TWO_BYTE_MASK[mem_instr[7:4]].
  - fire = state==RUN && !redirect_valid && (!out_valid || out_ready).
- Normal fetch, when fire and not (two && PC==255):
  - out_instr <= mem_instr.
  - out_operand <= two ? mem_next : 0.
  - out_pc <= PC.
  - out_two_byte <= two.
  - out_valid <= 1.
  - PC <= PC + (two ? 2 : 1), modulo 256. PC 255 one-byte wraps to 0; PC 254 two-byte wraps to 0.
- Throughput and latency:
  - One instruction per cycle while out_ready stays high.
  - First out_valid is asserted the cycle after reset deasserts.
- Consume without refill: if out_valid && out_ready and no fire (not RUN, or redirect), out_valid <= 0.
- Stall: out_valid && !out_ready holds every out_* field and the PC stable.
- HALT:
  - A fired byte equal to HALT_INSTR is issued normally, with PC advanced past it.
  - State goes to HALTED the same edge; no further fetches.
- Fault:
  - When fire && two && PC==255: nothing is issued and out_valid is unchanged unless consumed this cycle.
  - State goes to FAULT, and PC stays at 255.
- Redirect, when redirect_valid and state != FAULT:
  - PC <= redirect_addr; out_valid <= 0 (flush), even if a handshake completes that cycle. The consumer's acceptance stands, and the in-flight-next fetch is suppressed.
  - HALTED goes to RUN.
  - The first fetch from the target fires the following cycle; its instruction is valid two edges after redirect.
- In FAULT, redirect is ignored.
- The same fetched byte is never issued twice, and no byte is skipped except a two-byte operand.

Test Plan:
- Reset, memory {00:0x21, 01:0x35, 02:0xC7, 03:0x9A, 04:0x10}, out_ready=1 → issued (pc, instr, operand): (00,21,00), (01,35,00), (02,C7,9A, two_byte=1), (04,10,00) on consecutive cycles.
- Same program, out_ready=0 for 3 cycles after the first valid → out_instr=0x21 and out_pc=00 held for 3 cycles and mem_addr stays 01; with ready high again, the sequence resumes with no loss or duplication.
- redirect_valid with redirect_addr=0x40 while out_valid (pc 01) → next cycle out_valid=0, mem_addr=0x40; the cycle after, out_pc=0x40.
- HALT_INSTR at 0x05 → issued with out_pc=05; halted=1 the next cycle with no further valids. A redirect to 0x00 gives halted=0 and fetch resumes at 00.
- 0xD1 at 0xFF, PC reaches 0xFF → no issue, fault=1 persists; redirect is ignored; reset clears fault and PC=RESET_PC.
- One-byte 0x21 at 0xFF → issued; PC wraps to 0x00, and the next out_pc=0x00.
